// File: rtl/argmax_stream_10_16.sv
// rtl/argmax_stream_10_16.sv - streaming argmax classifier over M signed scores per vector
//
// Ports:
//   clk           - single clock, all state changes on the rising edge
//   reset         - asynchronous active-low reset
//   s_data_in_x   - signed score from the upstream layer
//   s_valid_x     - upstream data valid
//   s_ready_x     - block accepts s_data_in_x this cycle
//   m_data_out_y  - signed max score of the completed vector
//   m_index_y     - position (0..M-1) of the max within the vector
//   m_valid_y     - result register holds an unconsumed result
//   m_ready_y     - downstream accepts the result

module argmax_stream_10_16 #(
  parameter int WIDTH = 16,
  parameter int M     = 10,
  parameter int IDXW  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_x,
  input  logic                    s_valid_x,
  output logic                    s_ready_x,
  output logic signed [WIDTH-1:0] m_data_out_y,
  output logic [IDXW-1:0]         m_index_y,
  output logic                    m_valid_y,
  input  logic                    m_ready_y
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(M - 1);

  logic [IDXW-1:0]         r_cnt;
  logic signed [WIDTH-1:0] r_run_max;
  logic [IDXW-1:0]         r_run_idx;
  logic                    r_out_full;
  logic signed [WIDTH-1:0] r_out_data;
  logic [IDXW-1:0]         r_out_idx;

  logic w_last;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_gt;
  logic w_complete;

  assign w_last     = (r_cnt == LAST_IDX);
  // Only the final element of a vector can stall: it needs a free result slot,
  // which exists if the register is empty or is being drained on this same edge.
  assign s_ready_x  = !w_last || !r_out_full || m_ready_y;
  assign w_in_xfer  = s_valid_x && s_ready_x;
  assign w_out_xfer = r_out_full && m_ready_y;
  // Strict compare so ties keep the earlier (lower) index.
  assign w_gt       = (s_data_in_x > r_run_max);
  assign w_complete = w_in_xfer && w_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_run_max  <= '0;
      r_run_idx  <= '0;
      r_out_full <= 1'b0;
      r_out_data <= '0;
      r_out_idx  <= '0;
    end else begin
      if (w_in_xfer) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;

        if (r_cnt == '0) begin
          r_run_max <= s_data_in_x;
          r_run_idx <= '0;
        end else if (w_gt) begin
          r_run_max <= s_data_in_x;
          r_run_idx <= r_cnt;
        end
      end

      // The last element's compare goes straight into the result register so
      // the result is visible one cycle after the final handshake.
      if (w_complete) begin
        r_out_data <= w_gt ? s_data_in_x : r_run_max;
        r_out_idx  <= w_gt ? r_cnt : r_run_idx;
        r_out_full <= 1'b1;
      end else if (w_out_xfer) begin
        r_out_full <= 1'b0;
      end
    end
  end

  assign m_valid_y    = r_out_full;
  assign m_data_out_y = r_out_data;
  assign m_index_y    = r_out_idx;

endmodule

// File: tb/tb_argmax_stream_10_16.sv
// tb/tb_argmax_stream_10_16.sv - self-checking bench for argmax_stream_10_16

module tb_argmax_stream_10_16;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  i;
  } res_t;

  logic        clk;
  logic        reset;
  logic [15:0] s_data_in_x;
  logic        s_valid_x;
  logic        s_ready_x;
  logic [15:0] m_data_out_y;
  logic [3:0]  m_index_y;
  logic        m_valid_y;
  logic        m_ready_y;

  int checks;
  int errors;
  int n_results;
  int n_acc;
  int ready_lows;
  logic last_acc;

  logic [15:0] vec[$];
  res_t        exp_q[$];

  argmax_stream_10_16 dut (
    .clk          (clk),
    .reset        (reset),
    .s_data_in_x  (s_data_in_x),
    .s_valid_x    (s_valid_x),
    .s_ready_x    (s_ready_x),
    .m_data_out_y (m_data_out_y),
    .m_index_y    (m_index_y),
    .m_valid_y    (m_valid_y),
    .m_ready_y    (m_ready_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t amax(input logic [15:0] a [10]);
    res_t r;
    r.v = a[0];
    r.i = 4'd0;
    for (int k = 1; k < 10; k++) begin
      if ($signed(a[k]) > $signed(r.v)) begin
        r.v = a[k];
        r.i = 4'(k);
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] rnd_score();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'($urandom_range(0, 7));
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock cycle: drive, check outputs against the model mid-cycle, then
  // advance the model by whatever transfers happened on the rising edge.
  task automatic step(input logic v, input logic [15:0] d, input logic mr);
    logic        acc;
    logic        outx;
    logic        exp_ready;
    logic [15:0] tmp [10];
    s_valid_x   = v;
    s_data_in_x = v ? d : 16'hxxxx;
    m_ready_y   = mr;
    @(negedge clk);
    chk("m_valid", 32'(m_valid_y), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("m_data", 32'(m_data_out_y), 32'(exp_q[0].v));
      chk("m_index", 32'(m_index_y), 32'(exp_q[0].i));
    end
    exp_ready = !(vec.size() == 9 && exp_q.size() != 0 && !mr);
    chk("s_ready", 32'(s_ready_x), 32'(exp_ready));
    if (!s_ready_x) ready_lows++;
    acc  = v && s_ready_x;
    outx = m_valid_y && mr;
    @(posedge clk);
    if (outx && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      n_results++;
    end
    if (acc) begin
      n_acc++;
      vec.push_back(d);
      if (vec.size() == 10) begin
        for (int k = 0; k < 10; k++) tmp[k] = vec[k];
        exp_q.push_back(amax(tmp));
        vec.delete();
      end
    end
    last_acc = acc;
    #1;
  endtask

  task automatic feed_vec(input logic [15:0] a [10], input logic mr);
    for (int k = 0; k < 10; k++) step(1'b1, a[k], mr);
  endtask

  initial begin
    logic [15:0] t [10];
    logic [15:0] b [10];
    res_t        rb;
    int          base;
    int          lows0;
    int          nb;
    int          cyc;

    checks = 0; errors = 0; n_results = 0; n_acc = 0; ready_lows = 0;
    last_acc = 1'b0;
    reset = 1'b0; s_valid_x = 1'b0; s_data_in_x = 16'h0; m_ready_y = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("rst_valid", 32'(m_valid_y), 32'd0);
    chk("rst_data", 32'(m_data_out_y), 32'd0);
    chk("rst_index", 32'(m_index_y), 32'd0);
    chk("rst_ready", 32'(s_ready_x), 32'd1);
    reset = 1'b1;

    // Test 1: basic vector with duplicate max
    t = '{16'd3, -16'sd5, 16'd7, 16'd7, 16'd2, 16'd0, -16'sd1, 16'd6, 16'd1, 16'd4};
    feed_vec(t, 1'b1);
    chk("t1_valid", 32'(m_valid_y), 32'd1);
    chk("t1_data", 32'(m_data_out_y), 32'd7);
    chk("t1_index", 32'(m_index_y), 32'd2);
    step(1'b0, 16'h0, 1'b1);
    chk("t1_valid_drop", 32'(m_valid_y), 32'd0);

    // Test 2: negative and extreme vectors
    t = '{-16'sd8, -16'sd3, -16'sd9, -16'sd3, 16'h8000, -16'sd20, -16'sd4, -16'sd7, -16'sd5, -16'sd6};
    feed_vec(t, 1'b1);
    chk("t2a_data", 32'(m_data_out_y), 32'h0000FFFD);
    chk("t2a_index", 32'(m_index_y), 32'd1);
    for (int k = 0; k < 10; k++) t[k] = 16'h8000;
    feed_vec(t, 1'b1);
    chk("t2b_data", 32'(m_data_out_y), 32'h00008000);
    chk("t2b_index", 32'(m_index_y), 32'd0);
    t = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd5};
    feed_vec(t, 1'b1);
    chk("t2c_data", 32'(m_data_out_y), 32'd5);
    chk("t2c_index", 32'(m_index_y), 32'd9);
    step(1'b0, 16'h0, 1'b1);

    // Test 3: backpressure on the last element of the next vector
    t = '{16'd1, 16'd2, 16'd3, 16'd50, 16'd100, 16'd9, 16'd100, 16'd4, 16'd5, 16'd6};
    feed_vec(t, 1'b1);
    for (int k = 0; k < 10; k++) b[k] = rnd_score();
    rb = amax(b);
    nb = 0;
    for (int c = 0; c < 30; c++) begin
      step(1'b1, b[nb], 1'b0);
      if (last_acc) nb++;
    end
    chk("t3_accepted", 32'(nb), 32'd9);
    chk("t3_stall", 32'(s_ready_x), 32'd0);
    chk("t3_hold_data", 32'(m_data_out_y), 32'd100);
    chk("t3_hold_index", 32'(m_index_y), 32'd4);
    step(1'b1, b[9], 1'b1);
    chk("t3_last_acc", 32'(last_acc), 32'd1);
    chk("t3_b_valid", 32'(m_valid_y), 32'd1);
    chk("t3_b_data", 32'(m_data_out_y), 32'(rb.v));
    chk("t3_b_index", 32'(m_index_y), 32'(rb.i));
    step(1'b0, 16'h0, 1'b1);

    // Test 4: reset mid-vector discards the partial vector
    for (int k = 0; k < 4; k++) step(1'b1, 16'h7FFF, 1'b1);
    s_valid_x = 1'b0; m_ready_y = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("t4_async_valid", 32'(m_valid_y), 32'd0);
    chk("t4_async_ready", 32'(s_ready_x), 32'd1);
    chk("t4_async_data", 32'(m_data_out_y), 32'd0);
    vec.delete();
    exp_q.delete();
    @(posedge clk); #2;
    reset = 1'b1;
    base = n_results;
    for (int k = 0; k < 10; k++) step(1'b1, 16'($urandom_range(0, 1000)), 1'b1);
    step(1'b0, 16'h0, 1'b1);
    chk("t4_one_result", 32'(n_results - base), 32'd1);

    // Test 5: back-to-back vectors with the sink always ready
    base  = n_results;
    lows0 = ready_lows;
    for (int k = 0; k < 50; k++) step(1'b1, rnd_score(), 1'b1);
    step(1'b0, 16'h0, 1'b1);
    chk("t5_results", 32'(n_results - base), 32'd5);
    chk("t5_no_stall", 32'(ready_lows - lows0), 32'd0);

    // Test 6: random valid/ready against the reference model
    base = n_results;
    nb   = n_acc;
    cyc  = 0;
    while ((n_acc - nb) < 2340 && cyc < 30000) begin
      step(1'($urandom_range(0, 1)), rnd_score(), 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("t6_elements", 32'(n_acc - nb), 32'd2340);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      step(1'b0, 16'h0, 1'b1);
      cyc++;
    end
    chk("t6_results", 32'(n_results - base), 32'd234);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_final_valid", 32'(m_valid_y), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
